// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - operand / partial-product / accumulator widths
//   - FSM state encoding
//   - Booth digit encoding (neg, one, two) and its encoder function
// Optional feature macro used by the design: BOOTH_EARLY_TERM_EN
// ---------------------------------------------------------------------------
package booth_pkg;

  localparam int W     = 16;      // operand width (only 16 is supported)
  localparam int PP_W  = W + 3;   // partial-product width, sign-extended
  localparam int NPP   = W / 2;   // number of radix-4 digits
  localparam int ACC_W = 34;      // carry-save accumulator width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // One radix-4 digit: magnitude is one (|d|=1) or two (|d|=2), sign is neg.
  // Both magnitude flags low means the digit is zero.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  // Encode the multiplier triplet {b[2i+1], b[2i], b[2i-1]}.
  // The triplet 111 is a zero digit and is deliberately not marked negative,
  // so no +1 correction is ever injected for a zero partial product.
  function automatic booth_dig_t booth_encode(input logic [2:0] trip);
    booth_dig_t dig;
    dig.neg = trip[2] & ~(trip[1] & trip[0]);
    dig.one = trip[1] ^ trip[0];
    dig.two = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
    return dig;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// ---------------------------------------------------------------------------
// booth_pp_gen
// Combinational radix-4 Booth encoder and 19-bit partial-product generator.
// Ports:
//   i_a    [15:0] multiplicand, two's complement
//   i_trip [2:0]  multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//   o_pp   [18:0] partial product; for negative digits this is the one's
//                 complement of |d|*a, the +1 is added by the caller
//   o_neg         digit is negative
// ---------------------------------------------------------------------------
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic [W-1:0]    i_a,
  input  logic [2:0]      i_trip,
  output logic [PP_W-1:0] o_pp,
  output logic            o_neg
);

  booth_dig_t            w_dig;
  logic      [PP_W-1:0]  w_a_ext;
  logic      [PP_W-1:0]  w_mag;

  assign w_dig   = booth_encode(i_trip);
  assign w_a_ext = {{(PP_W-W){i_a[W-1]}}, i_a};

  // |d|*a selection; 2a of the most negative operand still fits in 19 bits
  always_comb begin
    w_mag = '0;
    if (w_dig.one)      w_mag = w_a_ext;
    else if (w_dig.two) w_mag = w_a_ext << 1;
  end

  assign o_pp  = w_dig.neg ? ~w_mag : w_mag;
  assign o_neg = w_dig.neg;

endmodule

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
// Iterative 16x16 signed radix-4 Booth multiplier. One partial product per
// cycle is folded into a registered 34-bit carry-save accumulator; a final
// carry-propagate add resolves the product.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b       [15:0]    signed multiplicand / multiplier
//   out_valid / out_ready product handshake
//   p          [31:0]    signed product, held stable while back-pressured
//   busy                 high in any state other than IDLE
// Configuration macro: BOOTH_EARLY_TERM_EN
//   defined   - stop accumulating once the remaining multiplier bits are all
//               sign copies (all remaining digits are zero)
//   undefined - all eight digits are always processed
// ---------------------------------------------------------------------------
module booth_mul_seq
  import booth_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] p,
  output logic          busy
);

  state_t              r_state;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [ACC_W-1:0]    r_sum;
  logic [ACC_W-1:0]    r_carry;
  logic [NPP-1:0]      r_negs;
  logic [2:0]          r_idx;
  logic [2*W-1:0]      r_p;
  logic                r_out_valid;

  logic [W:0]          w_bext;
  logic [3:0]          w_shamt;
  logic [2:0]          w_trip;
  logic [PP_W-1:0]     w_pp;
  logic                w_neg;
  logic [ACC_W-1:0]    w_pp_sh;
  logic [ACC_W-1:0]    w_csa_sum;
  logic [ACC_W-1:0]    w_csa_carry;
  logic [ACC_W-1:0]    w_corr;
  logic [2*W-1:0]      w_final;
  logic [ACC_W-2*W-1:0] w_unused_hi;
  logic                w_last;

  // b[-1] = 0 is supplied by appending a zero below the multiplier
  assign w_bext  = {r_b, 1'b0};
  assign w_shamt = {r_idx, 1'b0};
  assign w_trip  = w_bext[w_shamt +: 3];

  booth_pp_gen u_pp_gen (
    .i_a    (r_a),
    .i_trip (w_trip),
    .o_pp   (w_pp),
    .o_neg  (w_neg)
  );

  assign w_pp_sh = {{(ACC_W-PP_W){w_pp[PP_W-1]}}, w_pp} << w_shamt;

  // One 3:2 CSA level: sum, carry and the shifted partial product
  assign w_csa_sum   = r_sum ^ r_carry ^ w_pp_sh;
  assign w_csa_carry = ((r_sum & r_carry) | (r_sum & w_pp_sh) | (r_carry & w_pp_sh)) << 1;

  // The +1 for each negative digit sits at bit 2i. These are collected in
  // r_negs and only expanded here, because bit 2i of the shifted carry vector
  // may already be occupied; the positions of different digits never overlap.
  always_comb begin
    w_corr = '0;
    for (int k = 0; k < NPP; k++) begin
      w_corr[2*k] = r_negs[k];
    end
  end

  assign {w_unused_hi, w_final} = r_sum + r_carry + w_corr;

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining digits are all zero when b[15:2i+1] are copies of one bit
  logic signed [W-1:0] w_tail;
  assign w_tail = $signed(r_b) >>> ({1'b0, w_shamt} + 5'd1);
  assign w_last = (r_idx == 3'(NPP-1)) || (w_tail == '0) || (&w_tail);
`else
  assign w_last = (r_idx == 3'(NPP-1));
`endif

  // Control FSM and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_negs      <= '0;
      r_idx       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= '0;
            r_negs  <= '0;
            r_idx   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_sum         <= w_csa_sum;
          r_carry       <= w_csa_carry;
          r_negs[r_idx] <= w_neg;
          r_idx         <= r_idx + 3'd1;
          if (w_last) r_state <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          r_p         <= w_final;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign p         = r_p;

endmodule
